// File: rtl/mux_sel_sequencer_if.sv
// Control/status bundle between a run controller and the mux select sequencer.
// The slave side is the sequencer; the master side programs it and observes status.
interface mux_sel_sequencer_if #(
    parameter int DWELL_W = 8,
    parameter int FCNT_W  = 8
);
    logic               en;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         ch_mask;
    logic [1:0]         sel;
    logic               sel_valid;
    logic               sample_stb;
    logic               frame_done;
    logic               busy;
    logic [FCNT_W-1:0]  frame_cnt;

    modport master (
        output en, dwell, ch_mask,
        input  sel, sel_valid, sample_stb, frame_done, busy, frame_cnt
    );

    modport slave (
        input  en, dwell, ch_mask,
        output sel, sel_valid, sample_stb, frame_done, busy, frame_cnt
    );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Round-robin select sequencer for a 4:1 mux. Each enabled channel is held for
// dwell+1 cycles; sample_stb marks the last (settled) cycle of every dwell and
// frame_done marks the strobe after which the scan wraps back to the lowest channel.
module mux_sel_sequencer #(
    parameter int DWELL_W = 8,
    parameter int FCNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_sel_sequencer_if.slave bus
);

    typedef enum logic {IDLE, DWELL} state_t;

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic               vld_q, vld_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;

    logic [1:0] first_ch;
    logic [1:0] next_ch;
    logic       above;
    logic       stb;
    logic       fdone;

    // Channel search: lowest enabled channel, next enabled channel after sel
    // (wrapping), and whether any enabled channel remains above sel this frame.
    always_comb begin
        first_ch = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (bus.ch_mask[i]) first_ch = 2'(i);

        // Smallest forward distance wins; distance 4 falls back to sel itself.
        next_ch = sel_q;
        for (int k = 3; k >= 1; k--)
            if (bus.ch_mask[sel_q + 2'(k)]) next_ch = sel_q + 2'(k);

        above = 1'b0;
        for (int i = 0; i < 4; i++)
            if (i > int'(sel_q) && bus.ch_mask[i]) above = 1'b1;

        // Strobe comes purely from registered state so it is glitch-free.
        stb   = (state_q == DWELL) && (cnt_q == dwell_q);
        fdone = stb && !above;
    end

    // Next-state logic: start, dwell count, advance or graceful stop.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (bus.en && (bus.ch_mask != 4'd0)) begin
                    state_d = DWELL;
                    sel_d   = first_ch;
                    cnt_d   = '0;
                    dwell_d = bus.dwell;
                    vld_d   = 1'b1;
                end
            end
            DWELL: begin
                if (stb) begin
                    if (fdone) fcnt_d = fcnt_q + 1'b1;
                    // The current dwell has finished; stop only at this boundary.
                    if (!bus.en || (bus.ch_mask == 4'd0)) begin
                        state_d = IDLE;
                        vld_d   = 1'b0;
                    end else begin
                        sel_d   = next_ch;
                        cnt_d   = '0;
                        dwell_d = bus.dwell;
                    end
                end else if (cnt_q < dwell_q) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.sel_valid  = vld_q;
    assign bus.sample_stb = stb;
    assign bus.frame_done = fdone;
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed, table-driven bench for mux_sel_sequencer. Each table row is one
// clock: inputs are applied before the edge and outputs checked just after it.
module tb_mux_sel_sequencer;

    logic clk;
    logic rst_n;

    mux_sel_sequencer_if #(.DWELL_W(8), .FCNT_W(8)) bus ();

    mux_sel_sequencer #(.DWELL_W(8), .FCNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [7:0] dwell;
        logic [3:0] mask;
        logic [13:0] exp;   // {sel, sel_valid, sample_stb, frame_done, busy, frame_cnt}
    } vec_t;

    vec_t vq[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic v(input logic r, input logic e, input logic [7:0] d, input logic [3:0] m,
                     input logic [1:0] s, input logic vl, input logic st, input logic fd,
                     input logic b, input logic [7:0] c, input int n = 1);
        vec_t t;
        t.rst_n = r; t.en = e; t.dwell = d; t.mask = m;
        t.exp   = {s, vl, st, fd, b, c};
        repeat (n) vq.push_back(t);
    endtask

    function automatic logic [13:0] outs();
        return {bus.sel, bus.sel_valid, bus.sample_stb, bus.frame_done, bus.busy, bus.frame_cnt};
    endfunction

    task automatic chk(input string nm, input logic [13:0] got, input logic [13:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got sel/vld/stb/fd/busy/fcnt=%b_%b_%b_%b_%b_%0d want %b_%b_%b_%b_%b_%0d",
                     nm, got[13:12], got[11], got[10], got[9], got[8], got[7:0],
                     exp[13:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [7:0] d, input logic [3:0] m);
        @(negedge clk);
        rst_n = r; bus.en = e; bus.dwell = d; bus.ch_mask = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; bus.en = 1'b0; bus.dwell = '0; bus.ch_mask = '0;

        // reset, then empty mask with en high stays idle
        v(0,0,3,4'hF, 0,0,0,0,0,0);
        v(1,1,3,4'h0, 0,0,0,0,0,0, 2);
        // dwell=3, all channels: 0,1,2,3 four cycles each, wrap on 16
        v(1,1,3,4'hF, 0,1,0,0,1,0, 3); v(1,1,3,4'hF, 0,1,1,0,1,0);
        v(1,1,3,4'hF, 1,1,0,0,1,0, 3); v(1,1,3,4'hF, 1,1,1,0,1,0);
        v(1,1,3,4'hF, 2,1,0,0,1,0, 3); v(1,1,3,4'hF, 2,1,1,0,1,0);
        v(1,1,3,4'hF, 3,1,0,0,1,0, 3); v(1,1,3,4'hF, 3,1,1,1,1,0);
        v(1,1,3,4'hF, 0,1,0,0,1,1, 3); v(1,1,3,4'hF, 0,1,1,0,1,1);
        v(1,1,3,4'hF, 1,1,0,0,1,1, 3); v(1,1,3,4'hF, 1,1,1,0,1,1);
        v(1,1,3,4'hF, 2,1,0,0,1,1, 2);
        // en dropped at cnt=1 of channel 2: dwell completes, then idle holding sel=2
        v(1,0,3,4'hF, 2,1,0,0,1,1); v(1,0,3,4'hF, 2,1,1,0,1,1);
        v(1,0,3,4'hF, 2,0,0,0,0,1, 2);
        // dwell=1, mask 1010: 1,3,1,3 two cycles each, frame_done with sel=3
        v(1,1,1,4'hA, 1,1,0,0,1,1); v(1,1,1,4'hA, 1,1,1,0,1,1);
        v(1,1,1,4'hA, 3,1,0,0,1,1); v(1,1,1,4'hA, 3,1,1,1,1,1);
        v(1,1,1,4'hA, 1,1,0,0,1,2); v(1,1,1,4'hA, 1,1,1,0,1,2);
        v(1,1,1,4'hA, 3,1,0,0,1,2); v(1,1,1,4'hA, 3,1,1,1,1,2);
        v(1,1,1,4'hA, 1,1,0,0,1,3);
        v(1,0,1,4'hA, 1,1,1,0,1,3); v(1,0,1,4'hA, 1,0,0,0,0,3);
        // mask 1111 -> 0001 and dwell 2 -> 3 mid-dwell on sel=1
        v(1,1,2,4'hF, 0,1,0,0,1,3, 2); v(1,1,2,4'hF, 0,1,1,0,1,3);
        v(1,1,2,4'hF, 1,1,0,0,1,3);
        v(1,1,3,4'h1, 1,1,0,0,1,3); v(1,1,3,4'h1, 1,1,1,1,1,3);
        v(1,1,3,4'h1, 0,1,0,0,1,4, 3); v(1,1,3,4'h1, 0,1,1,1,1,4);
        v(1,1,3,4'h1, 0,1,0,0,1,5, 3);
        // reset mid-dwell at cnt=2
        v(0,1,3,4'h1, 0,0,0,0,0,0); v(1,0,3,4'h1, 0,0,0,0,0,0);

        foreach (vq[i]) begin
            drive(vq[i].rst_n, vq[i].en, vq[i].dwell, vq[i].mask);
            chk($sformatf("vec%0d", i), outs(), vq[i].exp);
        end

        // single channel, dwell=0: strobe and frame_done every cycle, counter wraps
        drive(1, 1, 0, 4'h4);
        chk("single_start", outs(), {2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0});
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk); #1;
            chk($sformatf("single_k%0d", k), outs(), {2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'(k)});
        end
        // graceful stop: last 1-cycle dwell still counts its frame
        drive(1, 0, 0, 4'h4);
        chk("single_stop", outs(), {2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
